// File: rtl/gpio_cap_pkg.sv
// Shared types, default window/frame constants and the window-decode helper
// for the GPIO capture stream.
package gpio_cap_pkg;

  typedef logic [7:0]  byte_t;
  typedef logic [31:0] addr_t;

  localparam addr_t       DEF_WIN_BASE    = 32'd152100;
  localparam addr_t       DEF_WIN_LAST    = 32'd304199;
  localparam int unsigned DEF_FRAME_BYTES = 32'd152100;
  localparam int unsigned DEF_DEPTH       = 32'd16;

  // Inclusive unsigned window test.
  function automatic logic in_window(input addr_t addr, input addr_t base, input addr_t last);
    return (addr >= base) && (addr <= last);
  endfunction

endpackage

// File: rtl/gpio_capture_stream_fifo.sv
// First-word-fall-through byte FIFO with a registered head byte that holds
// its last value once the FIFO runs empty.
module byte_fifo
  import gpio_cap_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [7:0]                 din,
  input  logic                       pop,
  output logic [7:0]                 dout,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH+1);

  byte_t              mem_q [DEPTH];
  byte_t              mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   rd_nxt;
  logic [LVL_W-1:0]   level_q, level_d;
  byte_t              dout_q, dout_d;

  // Storage, pointer, occupancy and head-byte next-state.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    dout_d   = dout_q;
    rd_nxt   = rd_ptr_q + PTR_W'(1);

    if (push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop) begin
      rd_ptr_d = rd_nxt;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    // Head after a pop comes from storage unless the FIFO held only the popped byte.
    if (pop) begin
      if (level_q > LVL_W'(1)) begin
        dout_d = mem_q[rd_nxt];
      end else if (push) begin
        dout_d = din;
      end else begin
        dout_d = dout_q;
      end
    end else if (push && (level_q == LVL_W'(0))) begin
      dout_d = din;
    end else begin
      dout_d = dout_q;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: 8'h00};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      dout_q   <= 8'h00;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      dout_q   <= dout_d;
    end
  end

  assign dout  = dout_q;
  assign level = level_q;

endmodule

// File: rtl/gpio_capture_stream.sv
// Captures GPIO writes inside an address window into a byte stream with frame
// and overflow tracking. Define GPIO_CAP_SEQ_CHECK_EN to add the seq_err port.
module gpio_capture_stream
  import gpio_cap_pkg::*;
#(
  parameter addr_t       WIN_BASE    = DEF_WIN_BASE,
  parameter addr_t       WIN_LAST    = DEF_WIN_LAST,
  parameter int unsigned DEPTH       = DEF_DEPTH,
  parameter int unsigned FRAME_BYTES = DEF_FRAME_BYTES
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                GPIOaddr,
  input  logic [7:0]                 GPIO,
  input  logic                       GPIOEn,
  output logic [7:0]                 out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       frame_done,
  output logic                       overflow
`ifdef GPIO_CAP_SEQ_CHECK_EN
  , output logic                     seq_err
`endif
);

  localparam int unsigned LVL_W = $clog2(DEPTH+1);

  logic             hit, push, pop;
  logic [31:0]      cnt_q, cnt_d, cnt_inc;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;

  assign out_valid = (level != LVL_W'(0));
  assign pop       = out_valid && out_ready;
  assign hit       = GPIOEn && in_window(GPIOaddr, WIN_BASE, WIN_LAST);
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign push      = hit && ((level < LVL_W'(DEPTH)) || pop);

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (GPIO),
    .pop   (pop),
    .dout  (out_data),
    .level (level)
  );

  // Frame counter, frame pulse and sticky overflow next-state.
  always_comb begin
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    cnt_inc = cnt_q + 32'd1;

    if (push) begin
      if (cnt_inc == FRAME_BYTES) begin
        cnt_d  = 32'd0;
        done_d = 1'b1;
      end else begin
        cnt_d  = cnt_inc;
      end
    end else begin
      cnt_d = cnt_q;
    end

    if (hit && !push) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Frame/overflow registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= 32'd0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
      ovf_q  <= ovf_d;
    end
  end

  assign frame_done = done_q;
  assign overflow   = ovf_q;

`ifdef GPIO_CAP_SEQ_CHECK_EN
  addr_t exp_q, exp_d;
  logic  seq_q, seq_d;

  // Expected next address follows each accepted byte, wrapping at the window end.
  always_comb begin
    exp_d = exp_q;
    seq_d = seq_q;
    if (push) begin
      seq_d = seq_q || (GPIOaddr != exp_q);
      exp_d = (GPIOaddr == WIN_LAST) ? WIN_BASE : (GPIOaddr + 32'd1);
    end else begin
      exp_d = exp_q;
      seq_d = seq_q;
    end
  end

  // Sequence-check registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q <= WIN_BASE;
      seq_q <= 1'b0;
    end else begin
      exp_q <= exp_d;
      seq_q <= seq_d;
    end
  end

  assign seq_err = seq_q;
`endif

endmodule

// File: tb/tb_gpio_capture_stream.sv
// Randomized + directed bench for gpio_capture_stream against a queue-based
// reference model (FRAME_BYTES shortened to 25).
module tb_gpio_capture_stream;

  localparam logic [31:0] WB    = 32'd152100;
  localparam logic [31:0] WL    = 32'd304199;
  localparam int          DEPTH = 16;
  localparam int          FB    = 25;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] GPIOaddr;
  logic [7:0]  GPIO;
  logic        GPIOEn;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  level;
  logic        frame_done;
  logic        overflow;
`ifdef GPIO_CAP_SEQ_CHECK_EN
  logic        seq_err;
`endif

  gpio_capture_stream #(
    .WIN_BASE(WB), .WIN_LAST(WL), .DEPTH(DEPTH), .FRAME_BYTES(FB)
  ) dut (
    .clk(clk), .rst(rst), .GPIOaddr(GPIOaddr), .GPIO(GPIO), .GPIOEn(GPIOEn),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .frame_done(frame_done), .overflow(overflow)
`ifdef GPIO_CAP_SEQ_CHECK_EN
    , .seq_err(seq_err)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic [7:0]  mq[$];
  logic [7:0]  m_dout;
  logic        m_ovf, m_done, m_seq;
  int          m_cnt;
  logic [31:0] m_exp;

  logic [7:0]  got[$];
  int          n_pulse;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_all();
    check_val("level", 32'(level), 32'(mq.size()));
    check_val("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    check_val("out_data", 32'(out_data), 32'(m_dout));
    check_val("frame_done", 32'(frame_done), 32'(m_done));
    check_val("overflow", 32'(overflow), 32'(m_ovf));
`ifdef GPIO_CAP_SEQ_CHECK_EN
    check_val("seq_err", 32'(seq_err), 32'(m_seq));
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1; GPIOEn = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete();
    m_dout = 8'h00; m_ovf = 1'b0; m_done = 1'b0; m_seq = 1'b0;
    m_cnt = 0; m_exp = WB;
    check_all();
  endtask

  task automatic step(input logic en, input logic [31:0] addr, input logic [7:0] data, input logic rdy);
    logic pop, hit, push;
    GPIOEn = en; GPIOaddr = addr; GPIO = data; out_ready = rdy;
    @(negedge clk);
    if (out_valid && out_ready) got.push_back(out_data);
    @(posedge clk);
    pop  = (mq.size() != 0) && rdy;
    hit  = en && (addr >= WB) && (addr <= WL);
    push = hit && ((mq.size() < DEPTH) || pop);
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back(data);
    if (hit && !push) m_ovf = 1'b1;
    m_done = 1'b0;
    if (push) begin
      m_cnt++;
      if (m_cnt == FB) begin m_done = 1'b1; m_cnt = 0; end
      if (addr != m_exp) m_seq = 1'b1;
      m_exp = (addr == WL) ? WB : addr + 32'd1;
    end
    if (mq.size() != 0) m_dout = mq[0];
    #1;
    if (frame_done) n_pulse++;
    check_all();
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 5))
      0:       return WB - 32'd1;
      1:       return WB;
      2:       return WL;
      3:       return WL + 32'd1;
      4:       return 32'($urandom);
      default: return 32'($urandom_range(WB, WL));
    endcase
  endfunction

  logic [7:0] bp[17];

  initial begin
    rst = 1'b1; GPIOaddr = 32'd0; GPIO = 8'h00; GPIOEn = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    do_reset();

    // window edges
    got.delete();
    step(1'b1, WB - 32'd1, 8'hAA, 1'b1);
    step(1'b1, WB,         8'hBB, 1'b1);
    step(1'b1, WL,         8'hCC, 1'b1);
    step(1'b1, WL + 32'd1, 8'hDD, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 8'h00, 1'b1);
    check_val("edge_count", 32'(got.size()), 32'd2);
    if (got.size() == 2) begin
      check_val("edge_first", 32'(got[0]), 32'hBB);
      check_val("edge_second", 32'(got[1]), 32'hCC);
    end
    check_val("edge_ovf", 32'(overflow), 32'd0);

    // strobe gating
    step(1'b0, WB, 8'h55, 1'b1);
    check_val("gate_level", 32'(level), 32'd0);

    // backpressure and drop
    do_reset();
    got.delete();
    for (int i = 0; i < 17; i++) begin
      bp[i] = 8'($urandom);
      step(1'b1, WB + 32'(i), bp[i], 1'b0);
      if (i == 15) check_val("bp_full", 32'(level), 32'd16);
    end
    check_val("bp_ovf", 32'(overflow), 32'd1);
    check_val("bp_level", 32'(level), 32'd16);
    for (int i = 0; i < 18; i++) step(1'b0, 32'd0, 8'h00, 1'b1);
    check_val("bp_drain_count", 32'(got.size()), 32'd16);
    for (int i = 0; i < 16 && i < got.size(); i++) check_val("bp_order", 32'(got[i]), 32'(bp[i]));

    // full with simultaneous pop and push
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, WB + 32'(i), 8'(i), 1'b0);
    step(1'b1, WB + 32'd16, 8'h77, 1'b1);
    check_val("fullpp_level", 32'(level), 32'd16);
    check_val("fullpp_ovf", 32'(overflow), 32'd0);

    // frame pulse
    do_reset();
    n_pulse = 0;
    for (int i = 0; i < FB; i++) step(1'b1, WB + 32'(i), 8'($urandom), 1'b1);
    check_val("frame_pulse_at_25", 32'(frame_done), 32'd1);
    step(1'b1, WB + 32'd25, 8'h01, 1'b1);
    check_val("frame_pulse_one_cycle", 32'(frame_done), 32'd0);
    for (int i = 0; i < FB - 1; i++) step(1'b1, WB + 32'(26 + i), 8'($urandom), 1'b1);
    check_val("frame_pulse_total", 32'(n_pulse), 32'd2);

    // reset mid-stream
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, WB + 32'(i), 8'(i + 1), 1'b0);
    check_val("mid_level", 32'(level), 32'd5);
    do_reset();
    check_val("mid_rst_level", 32'(level), 32'd0);
    check_val("mid_rst_valid", 32'(out_valid), 32'd0);

`ifdef GPIO_CAP_SEQ_CHECK_EN
    step(1'b1, WB, 8'h10, 1'b1);
    check_val("seq_ok", 32'(seq_err), 32'd0);
    step(1'b1, WB + 32'd2, 8'h11, 1'b1);
    check_val("seq_gap", 32'(seq_err), 32'd1);
`endif

    // randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else step(1'($urandom), rand_addr(), 8'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gpio_capture_stream.md
Name: gpio_capture_stream

Overview:
- Downstream consumer of the processor's GPIO write port.
- Watches the GPIOaddr, GPIO and GPIOEn bus each cycle and captures bytes whose address falls in the output window (default 152100..304199).
- Buffers captured bytes in a FIFO and drains them over a ready/valid byte stream to an external sink (UART or host bridge).
- Tracks frame completion and overflow for the host.

Parameters:
- WIN_BASE, 152100, first captured address (inclusive).
- WIN_LAST, 304199, last captured address (inclusive).
- DEPTH, 16, FIFO entries; power of two, at least 2.
- FRAME_BYTES, 152100, accepted bytes per frame.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- GPIOaddr  in  32  processor write address.
- GPIO  in  8  processor write data.
- GPIOEn  in  1  processor write strobe; one write per cycle when high.
- out_data  out  8  FIFO head byte.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  sink accepts out_data this cycle.
- level  out  $clog2(DEPTH+1)  current FIFO occupancy.
- frame_done  out  1  one-cycle pulse when a frame's last byte is accepted.
- overflow  out  1  sticky; a window byte was dropped.

Behaviour:
- Interface: one clock (clk); synchronous, active-high reset (rst).
- Reset values: level=0, out_valid=0, out_data=0, frame_done=0, overflow=0, frame byte counter=0, FIFO pointers=0. Reset mid-stream discards FIFO contents with no further handshakes.
- Hit condition: hit = GPIOEn && WIN_BASE <= GPIOaddr <= WIN_LAST, unsigned 32-bit compares. Both boundary addresses are inclusive.
- Pop: pop = out_valid && out_ready.
- Push: push = hit && (level<DEPTH || pop).
  - When full with a simultaneous pop, the push is accepted and level stays at DEPTH.
- Drop: hit && !push sets overflow. overflow clears only on rst.
- Write latency: a byte captured at edge N appears on out_data/out_valid after edge N (one cycle).
- FWFT read: out_data is a registered head, no read latency. out_data holds its value while out_valid && !out_ready. When empty, out_data holds the last value.
- Level update: level += push - pop; saturates at neither bound by construction.
- Pointer wrap: read and write pointers are $clog2(DEPTH) bits and wrap naturally.
- Frame counting: counter counts pushes only, not drops.
  - On the push that makes count == FRAME_BYTES: frame_done=1 for exactly one cycle and the counter returns to 0.
  - Dropped bytes never advance the counter, so a frame with drops completes late; the host detects this via overflow.
- State: no explicit FSM beyond FIFO occupancy (EMPTY / PARTIAL / FULL derived from level) and the frame counter.

Optional Feature:
- Macro: GPIO_CAP_SEQ_CHECK_EN.
- With the macro defined: adds output port seq_err (1 bit, sticky, reset 0) and an internal expected-address register (reset WIN_BASE).
  - On each push, seq_err sets if GPIOaddr != expected.
  - expected then becomes GPIOaddr+1, or WIN_BASE if GPIOaddr == WIN_LAST.
- Without the macro: no seq_err port and no expected-address logic; behaviour otherwise identical.

Decomposition:
- Package gpio_cap_pkg holds:
  - default WIN_BASE, WIN_LAST, FRAME_BYTES constants;
  - typedef byte_t (logic [7:0]);
  - typedef addr_t (logic [31:0]).
- Sub-module byte_fifo (parameter DEPTH; ports clk, rst, push, din, pop, dout, level) holds storage and pointers.
- Top holds the window decode, overflow, frame counter and sequence check.

Test Plan:
- Window edges: with out_ready=1, write 0xAA@152099, 0xBB@152100, 0xCC@304199, 0xDD@304200 -> only 0xBB, 0xCC emerge, in order; overflow=0.
- Strobe gating: GPIOEn=0 with addr=152100, data=0x55 -> nothing captured; level stays 0.
- Backpressure: out_ready=0, 16 consecutive window writes -> level=16. A 17th write -> overflow=1, level=16. Then out_ready=1 -> first 16 bytes drain in order, and the 17th never appears.
- Full + simultaneous: level=16, out_ready=1 and a window write in the same cycle -> write accepted, level stays 16, no overflow.
- Frame pulse: FRAME_BYTES=25, 25 window writes with out_ready=1 -> frame_done high for exactly one cycle after the 25th capture edge. A 26th write starts a new frame count.
- Reset mid-stream and sequence check: level=5, assert rst for one cycle -> level=0, out_valid=0, overflow=0 next cycle. With GPIO_CAP_SEQ_CHECK_EN, writes @152100, @152102 -> seq_err=1 after the second push.
